// File: rtl/ship_gun_pkg.sv
// Shared widths, reset values and helpers for the player ship / gun datapath.
package ship_gun_pkg;

  localparam int X_W         = 5;
  localparam int Y_W         = 4;
  localparam int SCORE_W     = 8;
  localparam int DEB_SAMPLES = 3;

  localparam logic [X_W-1:0] SHIP_X_INIT = 5'd15;
  localparam logic [X_W-1:0] X_MAX       = 5'd31;
  localparam logic [Y_W-1:0] Y_START     = 4'd14;

  // Tick history that marks a fresh press: one low sample followed by all highs.
  localparam logic [DEB_SAMPLES-1:0] PRESS_PAT = {1'b0, {(DEB_SAMPLES-1){1'b1}}};

  typedef struct packed {
    logic           flying;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } bullet_t;

  // One saturating step of the ship column; opposing requests cancel out.
  function automatic logic [X_W-1:0] ship_step(input logic [X_W-1:0] x,
                                               input logic           dec,
                                               input logic           inc);
    ship_step = x;
    if (dec && !inc && x != '0)
      ship_step = x - 1'b1;
    else if (inc && !dec && x != X_MAX)
      ship_step = x + 1'b1;
  endfunction

endpackage

// File: rtl/btn_edge_pulse.sv
// Button conditioner: two-flop synchronizer, tick-rate history and a one-clock press pulse.
module btn_edge_pulse
  import ship_gun_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic btn,
  output logic pulse
);

  localparam int H_W = DEB_SAMPLES - 1;

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic [H_W-1:0] hist_q, hist_d;
  logic           pulse_q, pulse_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    pulse_d = 1'b0;
    if (enable) begin
      hist_d  = H_W'({hist_q, sync2_q});
      pulse_d = ({hist_q, sync2_q} == PRESS_PAT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/ship_gun_unit.sv
// Player ship position and single-bullet gun, advanced on the game tick.
// Optional hit counter is built when SCORE_EN is defined.
module ship_gun_unit
  import ship_gun_pkg::*;
(
  input  logic               clk_36MHz,
  input  logic               reset,
  input  logic               enable,
  input  logic               left,
  input  logic               right,
  input  logic               start,
  input  logic               shoot,
  input  logic               hit,
`ifdef SCORE_EN
  input  logic               clear_score,
  output logic [SCORE_W-1:0] score,
`endif
  output logic [X_W-1:0]     ship_x,
  output logic               start_debounced,
  output logic [X_W-1:0]     bullet_x,
  output logic [Y_W-1:0]     bullet_y,
  output logic               bullet_flying
);

  logic left_pulse, right_pulse, start_pulse;

  btn_edge_pulse u_left (
    .clk    (clk_36MHz),
    .rst_n  (reset),
    .enable (enable),
    .btn    (left),
    .pulse  (left_pulse)
  );

  btn_edge_pulse u_right (
    .clk    (clk_36MHz),
    .rst_n  (reset),
    .enable (enable),
    .btn    (right),
    .pulse  (right_pulse)
  );

  btn_edge_pulse u_start (
    .clk    (clk_36MHz),
    .rst_n  (reset),
    .enable (enable),
    .btn    (start),
    .pulse  (start_pulse)
  );

  logic [X_W-1:0] ship_x_q, ship_x_d;
  bullet_t        bullet_q, bullet_d;

  always_comb begin
    ship_x_d = ship_step(ship_x_q, left_pulse, right_pulse);
  end

  // A hit kills the bullet even between ticks and also blocks a same-cycle launch.
  always_comb begin
    bullet_d = bullet_q;
    if (hit) begin
      bullet_d.flying = 1'b0;
    end else if (enable) begin
      if (bullet_q.flying) begin
        if (bullet_q.y == '0)
          bullet_d.flying = 1'b0;
        else
          bullet_d.y = bullet_q.y - 1'b1;
      end else if (shoot) begin
        bullet_d.flying = 1'b1;
        bullet_d.x      = ship_x_q;
        bullet_d.y      = Y_START;
      end
    end
  end

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      ship_x_q <= SHIP_X_INIT;
      bullet_q <= '0;
    end else begin
      ship_x_q <= ship_x_d;
      bullet_q <= bullet_d;
    end
  end

`ifdef SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (clear_score)
      score_d = '0;
    else if (hit)
      score_d = score_q + 1'b1;
  end

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset)
      score_q <= '0;
    else
      score_q <= score_d;
  end

  assign score = score_q;
`endif

  assign ship_x          = ship_x_q;
  assign bullet_x        = bullet_q.x;
  assign bullet_y        = bullet_q.y;
  assign bullet_flying   = bullet_q.flying;
  assign start_debounced = start_pulse;

endmodule

// File: tb/tb_ship_gun_unit.sv
// Directed bench for ship_gun_unit with a per-cycle reference model and literal spot checks.
module tb_ship_gun_unit;

  logic       clk_36MHz = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       left = 1'b0, right = 1'b0, start = 1'b0;
  logic       shoot = 1'b0, hit = 1'b0;
  logic [4:0] ship_x, bullet_x;
  logic [3:0] bullet_y;
  logic       bullet_flying, start_debounced;
`ifdef SCORE_EN
  logic       clear_score = 1'b0;
  logic [7:0] score;
`endif

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;

  always #5 clk_36MHz = ~clk_36MHz;

  ship_gun_unit dut (
    .clk_36MHz       (clk_36MHz),
    .reset           (reset),
    .enable          (enable),
    .left            (left),
    .right           (right),
    .start           (start),
    .shoot           (shoot),
    .hit             (hit),
`ifdef SCORE_EN
    .clear_score     (clear_score),
    .score           (score),
`endif
    .ship_x          (ship_x),
    .start_debounced (start_debounced),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .bullet_flying   (bullet_flying)
  );

  // Reference model: raw buttons reach the tick sampler two clocks late; a press is
  // low,high,high over the last three tick samples; pulses move the ship a clock later.
  bit [2:0] raw_hist[$];
  bit [2:0] tick_hist[$];
  bit [2:0] m_pulse;
  int       m_ship, m_bx, m_by, m_score;
  bit       m_fly;

  always @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      raw_hist.delete();
      tick_hist.delete();
      m_pulse = '0;
      m_ship  = 15;
      m_bx    = 0;
      m_by    = 0;
      m_fly   = 0;
      m_score = 0;
    end else begin
      bit [2:0] raw, s, p1, p2;
      int n_ship;
      raw = {start, right, left};
      s   = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 3'b000;
      p1  = (tick_hist.size() >= 1) ? tick_hist[tick_hist.size()-1] : 3'b000;
      p2  = (tick_hist.size() >= 2) ? tick_hist[tick_hist.size()-2] : 3'b000;

      n_ship = m_ship + (m_pulse[1] ? 1 : 0) - (m_pulse[0] ? 1 : 0);
      if (n_ship < 0)  n_ship = 0;
      if (n_ship > 31) n_ship = 31;

      if (hit) begin
        m_fly = 0;
      end else if (enable && m_fly) begin
        if (m_by == 0) m_fly = 0;
        else           m_by  = m_by - 1;
      end else if (enable && shoot) begin
        m_fly = 1;
        m_bx  = m_ship;
        m_by  = 14;
      end
`ifdef SCORE_EN
      if (clear_score)  m_score = 0;
      else if (hit)     m_score = (m_score + 1) % 256;
`endif
      m_ship = n_ship;

      if (enable) begin
        m_pulse = ~p2 & p1 & s;
        tick_hist.push_back(s);
        if (tick_hist.size() > 2) void'(tick_hist.pop_front());
      end else begin
        m_pulse = '0;
      end
      raw_hist.push_back(raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    end
  end

  always @(posedge clk_36MHz) begin
    #2;
    if (reset === 1'b1) begin
      bit ok;
      ok = (ship_x === 5'(m_ship)) && (bullet_x === 5'(m_bx)) &&
           (bullet_y === 4'(m_by)) && (bullet_flying === m_fly) &&
           (start_debounced === m_pulse[2]);
`ifdef SCORE_EN
      ok = ok && (score === 8'(m_score));
`endif
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got ship=%0d bx=%0d by=%0d fly=%0b st=%0b want ship=%0d bx=%0d by=%0d fly=%0b st=%0b",
                 $time, ship_x, bullet_x, bullet_y, bullet_flying, start_debounced,
                 m_ship, m_bx, m_by, m_fly, m_pulse[2]);
      end
    end
  end

  always @(posedge clk_36MHz) if (start_debounced === 1'b1) start_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    repeat (3) @(negedge clk_36MHz);
    enable = 1'b1;
    @(negedge clk_36MHz);
    enable = 1'b0;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       left  = v;
      1:       right = v;
      default: start = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick();
    tick();
    set_btn(which, 1'b0);
    tick();
    tick();
  endtask

  task automatic hit_pulse();
    @(negedge clk_36MHz);
    hit = 1'b1;
    @(negedge clk_36MHz);
    hit = 1'b0;
  endtask

  initial begin
    bit toggle[4];
    toggle = '{1'b1, 1'b0, 1'b1, 1'b0};

    #1 reset = 1'b0;
    #1;
    chk("rst_ship_x", ship_x, 15);
    chk("rst_flying", bullet_flying, 0);
    chk("rst_bullet_x", bullet_x, 0);
    chk("rst_bullet_y", bullet_y, 0);
`ifdef SCORE_EN
    chk("rst_score", score, 0);
`endif
    repeat (2) @(negedge clk_36MHz);
    reset = 1'b1;

    right = 1'b1;
    repeat (5) tick();
    right = 1'b0;
    repeat (2) tick();
    chk("right_held_one_step", ship_x, 16);

    press(0);
    chk("left_back", ship_x, 15);

    foreach (toggle[i]) begin
      right = toggle[i];
      tick();
    end
    right = 1'b0;
    repeat (2) tick();
    chk("right_glitch_hold", ship_x, 15);

    repeat (15) press(0);
    chk("left_to_0", ship_x, 0);
    press(0);
    chk("left_sat_0", ship_x, 0);
    repeat (31) press(1);
    chk("right_to_31", ship_x, 31);
    press(1);
    chk("right_sat_31", ship_x, 31);
    repeat (11) press(0);
    chk("ship_at_20", ship_x, 20);

    left = 1'b1; right = 1'b1;
    tick(); tick();
    left = 1'b0; right = 1'b0;
    tick(); tick();
    chk("both_hold", ship_x, 20);

    shoot = 1'b1;
    tick();
    shoot = 1'b0;
    chk("launch_fly", bullet_flying, 1);
    chk("launch_x", bullet_x, 20);
    chk("launch_y", bullet_y, 14);
    repeat (14) tick();
    chk("top_y", bullet_y, 0);
    chk("top_fly", bullet_flying, 1);
    tick();
    chk("expire_fly", bullet_flying, 0);
    chk("expire_y", bullet_y, 0);

    shoot = 1'b1;
    tick();
    tick();
    chk("shoot_ignored_y", bullet_y, 13);
    shoot = 1'b0;
    repeat (6) tick();
    chk("pre_hit_y", bullet_y, 7);
    hit_pulse();
    chk("hit_fly", bullet_flying, 0);
    chk("hit_y_hold", bullet_y, 7);
    tick();
    chk("hit_y_after_tick", bullet_y, 7);

    shoot = 1'b1;
    repeat (3) @(negedge clk_36MHz);
    enable = 1'b1; hit = 1'b1;
    @(negedge clk_36MHz);
    enable = 1'b0; hit = 1'b0; shoot = 1'b0;
    chk("hit_blocks_launch", bullet_flying, 0);
    chk("hit_blocks_launch_y", bullet_y, 7);

`ifdef SCORE_EN
    chk("score_two_hits", score, 2);
    @(negedge clk_36MHz) clear_score = 1'b1;
    @(negedge clk_36MHz) clear_score = 1'b0;
    chk("score_clear", score, 0);
    repeat (3) hit_pulse();
    chk("score_three", score, 3);
    @(negedge clk_36MHz) begin hit = 1'b1; clear_score = 1'b1; end
    @(negedge clk_36MHz) begin hit = 1'b0; clear_score = 1'b0; end
    chk("clear_beats_hit", score, 0);
    @(negedge clk_36MHz) hit = 1'b1;
    repeat (255) @(negedge clk_36MHz);
    hit = 1'b0;
    chk("score_255", score, 255);
    hit_pulse();
    chk("score_wrap", score, 0);
`endif

    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    repeat (2) tick();
    chk("start_one_pulse", start_cnt, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("start_glitch", start_cnt, 1);

    press(1);
    shoot = 1'b1;
    tick();
    shoot = 1'b0;
    tick(); tick();
    chk("midflight_fly", bullet_flying, 1);
    chk("midflight_x", bullet_x, 21);
    @(negedge clk_36MHz);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_ship", ship_x, 15);
    chk("async_rst_fly", bullet_flying, 0);
    chk("async_rst_bx", bullet_x, 0);
    chk("async_rst_by", bullet_y, 0);
`ifdef SCORE_EN
    chk("async_rst_score", score, 0);
`endif
    @(negedge clk_36MHz);
    reset = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
